// File: rtl/servo_slew_pkg.sv
// Shared constants and FSM state type for the servo slew-rate limiter.
package servo_pkg;

  localparam int WIDTH      = 16;
  localparam int MAX_PW     = 20000;
  localparam int RESET_PW   = 1500;
  localparam int RESET_STEP = 10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    UPDATE = 2'd1,
    DONE   = 2'd2
  } state_t;

endpackage

// File: rtl/servo_slew_if.sv
// Register-bus / frame-strobe side and PWM-facing outputs of the slew limiter.
interface servo_slew_if #(
  parameter int NUM_CH = 8,
  parameter int WIDTH  = 16
);

  logic                      WEn;
  logic [7:0]                Addr;
  logic [7:0]                WData;
  logic                      Frame;
  logic [NUM_CH*WIDTH-1:0]   Cur;
  logic                      Busy;
  logic                      Done;
  logic                      Overrun;

  // Driver side: register writer plus frame source, observes the limiter state.
  modport master (
    output WEn, Addr, WData, Frame,
    input  Cur, Busy, Done, Overrun
  );

  // The slew limiter itself.
  modport slave (
    input  WEn, Addr, WData, Frame,
    output Cur, Busy, Done, Overrun
  );

endinterface

// File: rtl/servo_slew_step.sv
// Combinational single-channel step: moves cur toward tgt by at most step,
// never overshooting; step==0 jumps straight to the target.
module servo_slew_step #(
  parameter int W = servo_pkg::WIDTH
) (
  input  logic [W-1:0] i_cur,
  input  logic [W-1:0] i_tgt,
  input  logic [7:0]   i_step,
  output logic [W-1:0] o_next
);

  // One extra bit so neither the sum nor the difference can wrap.
  logic [W:0] w_cur_ext;
  logic [W:0] w_tgt_ext;
  logic [W:0] w_step_ext;
  logic [W:0] w_up;
  logic [W:0] w_dn;

  assign w_cur_ext  = {1'b0, i_cur};
  assign w_tgt_ext  = {1'b0, i_tgt};
  assign w_step_ext = (W+1)'(i_step);
  assign w_up       = w_cur_ext + w_step_ext;
  assign w_dn       = w_cur_ext - w_step_ext;

  // Pick the saturated next width; w_dn[W] flags an underflow below zero.
  always_comb begin
    o_next = i_cur;
    if (i_step == 8'd0) begin
      o_next = i_tgt;
    end else if (i_cur < i_tgt) begin
      o_next = (w_up >= w_tgt_ext) ? i_tgt : w_up[W-1:0];
    end else if (i_cur > i_tgt) begin
      o_next = (w_dn[W] || (w_dn <= w_tgt_ext)) ? i_tgt : w_dn[W-1:0];
    end
  end

endmodule

// File: rtl/servo_slew.sv
// Slew-rate limiter: per-channel targets written over the register bus,
// current widths walked toward them one channel per cycle after each frame.
module servo_slew #(
  parameter int         NUM_CH     = 8,
  parameter int         WIDTH      = servo_pkg::WIDTH,
  parameter int         MAX_PW     = servo_pkg::MAX_PW,
  parameter int         RESET_PW   = servo_pkg::RESET_PW,
  parameter int         RESET_STEP = servo_pkg::RESET_STEP,
  parameter logic [7:0] STEP_ADDR  = 8'h11
) (
  input logic         Clk,
  input logic         rst_n,
  servo_slew_if.slave bus
);

  import servo_pkg::*;

  localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  state_t              r_state;
  logic [IDX_W-1:0]    r_idx;
  logic                r_overrun;
  logic [7:0]          r_step;
  logic [7:0]          r_hold;
  logic [WIDTH-1:0]    r_tgt [NUM_CH];
  logic [WIDTH-1:0]    r_cur [NUM_CH];

  logic                w_is_ch;
  logic                w_is_step;
  logic                w_wr_low;
  logic [NUM_CH-1:0]   w_wr_high;
  logic [15:0]         w_commit_raw;
  logic [WIDTH-1:0]    w_commit;
  logic [WIDTH-1:0]    w_cur_sel;
  logic [WIDTH-1:0]    w_tgt_sel;
  logic [WIDTH-1:0]    w_cur_next;
  logic [NUM_CH*WIDTH-1:0] w_cur_flat;

  // Address decode: channel byte pairs live at 0..2*NUM_CH-1, step elsewhere.
  assign w_is_step    = bus.WEn && (bus.Addr == STEP_ADDR);
  assign w_is_ch      = bus.WEn && !w_is_step && (int'(bus.Addr) < 2*NUM_CH);
  assign w_wr_low     = w_is_ch && !bus.Addr[0];
  assign w_commit_raw = {bus.WData, r_hold};
  assign w_commit     = (int'(w_commit_raw) > MAX_PW) ? WIDTH'(MAX_PW)
                                                      : WIDTH'(w_commit_raw);

  // Shared low-byte holding register; the high-byte write commits it.
  always_ff @(posedge Clk or negedge rst_n) begin
    if (!rst_n)        r_hold <= 8'd0;
    else if (w_wr_low) r_hold <= bus.WData;
  end

  // Step register; a mid-sweep write affects only channels not yet processed.
  always_ff @(posedge Clk or negedge rst_n) begin
    if (!rst_n)         r_step <= 8'(RESET_STEP);
    else if (w_is_step) r_step <= bus.WData;
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
      assign w_wr_high[gi] = w_is_ch && bus.Addr[0] && (int'(bus.Addr[7:1]) == gi);

      // Target commit: both bytes land together so the target never tears.
      always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n)             r_tgt[gi] <= WIDTH'(RESET_PW);
        else if (w_wr_high[gi]) r_tgt[gi] <= w_commit;
      end

      // Current width moves only while this channel is the one being swept.
      always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n)
          r_cur[gi] <= WIDTH'(RESET_PW);
        else if ((r_state == UPDATE) && (int'(r_idx) == gi))
          r_cur[gi] <= w_cur_next;
      end
    end
  endgenerate

  // Single step unit shared by all channels; reads the pre-edge target, so a
  // same-cycle target write only takes effect on the next frame.
  assign w_cur_sel = r_cur[r_idx];
  assign w_tgt_sel = r_tgt[r_idx];

  servo_slew_step #(.W(WIDTH)) u_step (
    .i_cur  (w_cur_sel),
    .i_tgt  (w_tgt_sel),
    .i_step (r_step),
    .o_next (w_cur_next)
  );

  // Sweep sequencer: IDLE -> UPDATE (one channel per cycle) -> DONE -> IDLE.
  always_ff @(posedge Clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_idx     <= '0;
      r_overrun <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.Frame) begin
            r_state <= UPDATE;
            r_idx   <= '0;
          end
        end
        UPDATE: begin
          if (bus.Frame) r_overrun <= 1'b1;
          if (r_idx == IDX_W'(NUM_CH-1)) r_state <= DONE;
          else                           r_idx   <= r_idx + 1'b1;
        end
        DONE: begin
          if (bus.Frame) r_overrun <= 1'b1;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Flatten the current widths for the PWM comparator.
  always_comb begin
    w_cur_flat = '0;
    for (int k = 0; k < NUM_CH; k++) w_cur_flat[k*WIDTH +: WIDTH] = r_cur[k];
  end

  assign bus.Cur     = w_cur_flat;
  assign bus.Busy    = (r_state == UPDATE);
  assign bus.Done    = (r_state == DONE);
  assign bus.Overrun = r_overrun;

endmodule

// File: tb/tb_servo_slew.sv
// Directed bench for servo_slew: ramping, saturation, clamping, bypass,
// partial writes, same-cycle writes, overrun and asynchronous reset.
module tb_servo_slew;

  localparam int NCH = 8;
  localparam int W   = 16;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  servo_slew_if #(.NUM_CH(NCH), .WIDTH(W)) bus();

  servo_slew #(.NUM_CH(NCH), .WIDTH(W)) dut (
    .Clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] cur_of(input int k);
    return bus.Cur[k*W +: W];
  endfunction

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    bus.WEn = 1'b1; bus.Addr = a; bus.WData = d;
    @(negedge clk);
    bus.WEn = 1'b0;
    $display("write addr=%02h data=%02h", a, d);
  endtask

  task automatic pulse_frame();
    bus.Frame = 1'b1;
    @(negedge clk);
    bus.Frame = 1'b0;
  endtask

  task automatic run_frame();
    int n;
    pulse_frame();
    n = 0;
    while (bus.Done !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (bus.Done !== 1'b1) begin
      errors++;
      $display("FAIL done_timeout: Done=%b after %0d cycles, required 1", bus.Done, n);
    end
    @(negedge clk);
    $display("frame cur0=%0d cur1=%0d cur2=%0d cur5=%0d", cur_of(0), cur_of(1), cur_of(2), cur_of(5));
  endtask

  task automatic test_reset();
    for (int k = 0; k < NCH; k++) begin
      checks++;
      if (cur_of(k) !== 16'd1500) begin
        errors++; $display("FAIL reset_cur%0d: got %0d, required 1500", k, cur_of(k));
      end
    end
    checks++;
    if ({bus.Busy, bus.Done, bus.Overrun} !== 3'b000) begin
      errors++; $display("FAIL reset_flags: busy/done/ovr=%b, required 000", {bus.Busy, bus.Done, bus.Overrun});
    end
    pulse_frame();
    for (int i = 0; i < NCH; i++) begin
      checks++;
      if ({bus.Busy, bus.Done} !== 2'b10) begin
        errors++; $display("FAIL busy_cycle%0d: busy/done=%b, required 10", i, {bus.Busy, bus.Done});
      end
      @(negedge clk);
    end
    checks++;
    if ({bus.Busy, bus.Done} !== 2'b01) begin
      errors++; $display("FAIL done_pulse: busy/done=%b, required 01", {bus.Busy, bus.Done});
    end
    @(negedge clk);
    checks++;
    if ({bus.Busy, bus.Done} !== 2'b00) begin
      errors++; $display("FAIL done_end: busy/done=%b, required 00", {bus.Busy, bus.Done});
    end
    for (int k = 0; k < NCH; k++) begin
      checks++;
      if (cur_of(k) !== 16'd1500) begin
        errors++; $display("FAIL idle_frame_cur%0d: got %0d, required 1500", k, cur_of(k));
      end
    end
  endtask

  task automatic test_ramp();
    int exp;
    wr(8'h04, 8'hD0);
    wr(8'h05, 8'h07);
    wr(8'h11, 8'd10);
    // First frame by hand: channel 2 must change exactly at edge t+3.
    pulse_frame();
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (cur_of(2) !== 16'd1500) begin
      errors++; $display("FAIL ch2_early: got %0d, required 1500", cur_of(2));
    end
    @(negedge clk);
    checks++;
    if (cur_of(2) !== 16'd1510) begin
      errors++; $display("FAIL ch2_edge: got %0d, required 1510", cur_of(2));
    end
    repeat (5) @(negedge clk);
    checks++;
    if (bus.Done !== 1'b1) begin
      errors++; $display("FAIL ramp_done: Done=%b, required 1", bus.Done);
    end
    @(negedge clk);
    exp = 1510;
    for (int f = 2; f <= 51; f++) begin
      run_frame();
      exp = (exp + 10 > 2000) ? 2000 : exp + 10;
      checks++;
      if (cur_of(2) !== 16'(exp)) begin
        errors++; $display("FAIL ramp_f%0d: got %0d, required %0d", f, cur_of(2), exp);
      end
    end
    checks++;
    if (cur_of(3) !== 16'd1500) begin
      errors++; $display("FAIL ramp_ch3: got %0d, required 1500", cur_of(3));
    end
  endtask

  task automatic test_saturation();
    wr(8'h11, 8'd200);
    wr(8'h00, 8'h40);
    wr(8'h01, 8'h06);
    run_frame();
    checks++;
    if (cur_of(0) !== 16'd1600) begin
      errors++; $display("FAIL sat_up: got %0d, required 1600", cur_of(0));
    end
    wr(8'h00, 8'h00);
    wr(8'h01, 8'h00);
    run_frame();
    checks++;
    if (cur_of(0) !== 16'd1400) begin
      errors++; $display("FAIL step_down: got %0d, required 1400", cur_of(0));
    end
    wr(8'h00, 8'h46);
    wr(8'h01, 8'h05);
    run_frame();
    checks++;
    if (cur_of(0) !== 16'd1350) begin
      errors++; $display("FAIL sat_down: got %0d, required 1350", cur_of(0));
    end
    checks++;
    if (cur_of(2) !== 16'd2000) begin
      errors++; $display("FAIL sat_ch2_hold: got %0d, required 2000", cur_of(2));
    end
  endtask

  task automatic test_clamp_bypass();
    wr(8'h0A, 8'hFF); wr(8'h0B, 8'hFF);
    wr(8'h08, 8'h1F); wr(8'h09, 8'h4E);
    wr(8'h0C, 8'h20); wr(8'h0D, 8'h4E);
    wr(8'h0E, 8'h21); wr(8'h0F, 8'h4E);
    wr(8'h11, 8'h00);
    checks++;
    if (cur_of(5) !== 16'd1500) begin
      errors++; $display("FAIL cur_before_frame: got %0d, required 1500", cur_of(5));
    end
    run_frame();
    checks++;
    if (cur_of(5) !== 16'd20000) begin
      errors++; $display("FAIL clamp_ch5: got %0d, required 20000", cur_of(5));
    end
    checks++;
    if (cur_of(4) !== 16'd19999) begin
      errors++; $display("FAIL below_clamp_ch4: got %0d, required 19999", cur_of(4));
    end
    checks++;
    if (cur_of(6) !== 16'd20000) begin
      errors++; $display("FAIL at_clamp_ch6: got %0d, required 20000", cur_of(6));
    end
    checks++;
    if (cur_of(7) !== 16'd20000) begin
      errors++; $display("FAIL over_clamp_ch7: got %0d, required 20000", cur_of(7));
    end
    checks++;
    if (cur_of(0) !== 16'd1350) begin
      errors++; $display("FAIL bypass_ch0: got %0d, required 1350", cur_of(0));
    end
  endtask

  task automatic test_partial_write();
    wr(8'h11, 8'd10);
    wr(8'h02, 8'h34);
    run_frame();
    checks++;
    if (cur_of(1) !== 16'd1500) begin
      errors++; $display("FAIL low_only_ch1: got %0d, required 1500", cur_of(1));
    end
    wr(8'h03, 8'h07);
    run_frame();
    checks++;
    if (cur_of(1) !== 16'd1510) begin
      errors++; $display("FAIL commit_ch1: got %0d, required 1510", cur_of(1));
    end
  endtask

  task automatic test_same_cycle_write();
    wr(8'h02, 8'hDC);
    pulse_frame();
    @(negedge clk);
    // Commit ch1 = 1500 on the very edge that processes channel 1.
    bus.WEn = 1'b1; bus.Addr = 8'h03; bus.WData = 8'h05;
    @(negedge clk);
    bus.WEn = 1'b0;
    $display("write addr=03 data=05 during channel 1 update");
    checks++;
    if (cur_of(1) !== 16'd1520) begin
      errors++; $display("FAIL same_cycle_old_tgt: got %0d, required 1520", cur_of(1));
    end
    repeat (6) @(negedge clk);
    checks++;
    if (bus.Done !== 1'b1) begin
      errors++; $display("FAIL same_cycle_done: Done=%b, required 1", bus.Done);
    end
    @(negedge clk);
    run_frame();
    checks++;
    if (cur_of(1) !== 16'd1510) begin
      errors++; $display("FAIL same_cycle_new_tgt: got %0d, required 1510", cur_of(1));
    end
  endtask

  task automatic test_overrun();
    checks++;
    if (bus.Overrun !== 1'b0) begin
      errors++; $display("FAIL no_overrun_yet: got %b, required 0", bus.Overrun);
    end
    pulse_frame();
    repeat (3) @(negedge clk);
    pulse_frame();
    $display("frame issued while busy");
    checks++;
    if ({bus.Overrun, bus.Busy} !== 2'b11) begin
      errors++; $display("FAIL overrun_set: ovr/busy=%b, required 11", {bus.Overrun, bus.Busy});
    end
    repeat (4) @(negedge clk);
    checks++;
    if (bus.Done !== 1'b1) begin
      errors++; $display("FAIL overrun_no_restart: Done=%b, required 1", bus.Done);
    end
    @(negedge clk);
    checks++;
    if ({bus.Overrun, bus.Busy} !== 2'b10) begin
      errors++; $display("FAIL overrun_sticky: ovr/busy=%b, required 10", {bus.Overrun, bus.Busy});
    end
  endtask

  task automatic test_reset_mid_update();
    pulse_frame();
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    $display("reset asserted mid-update");
    checks++;
    if ({bus.Busy, bus.Done, bus.Overrun} !== 3'b000) begin
      errors++; $display("FAIL midreset_flags: busy/done/ovr=%b, required 000", {bus.Busy, bus.Done, bus.Overrun});
    end
    for (int k = 0; k < NCH; k++) begin
      checks++;
      if (cur_of(k) !== 16'd1500) begin
        errors++; $display("FAIL midreset_cur%0d: got %0d, required 1500", k, cur_of(k));
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_frame();
    checks++;
    if (cur_of(5) !== 16'd1500) begin
      errors++; $display("FAIL tgt_reset_ch5: got %0d, required 1500", cur_of(5));
    end
    wr(8'h00, 8'h40);
    wr(8'h01, 8'h06);
    run_frame();
    checks++;
    if (cur_of(0) !== 16'd1510) begin
      errors++; $display("FAIL step_reset: got %0d, required 1510", cur_of(0));
    end
  endtask

  initial begin
    bus.WEn = 1'b0; bus.Addr = 8'h00; bus.WData = 8'h00; bus.Frame = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_reset();
    test_ramp();
    test_saturation();
    test_clamp_bypass();
    test_partial_write();
    test_same_cycle_write();
    test_overrun();
    test_reset_mid_update();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
